// File: rtl/gt_cache_pkg.sv
// Shared types and helpers for the set-associative cache: FSM encoding,
// address-field sizing and tree pseudo-LRU update / victim selection.
package gt_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_MISS_WAIT = 2'd2,
        ST_FILL      = 2'd3
    } state_t;

    // Tree state sized for the largest supported associativity (8 ways).
    localparam int PLRU_W = 7;

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit of 0 means the
    // LRU side is the left subtree. Touching a way points every node on its
    // path away from it.
    function automatic logic [PLRU_W-1:0] plru_update(input logic [PLRU_W-1:0] bits,
                                                      input logic [2:0] way,
                                                      input int unsigned levels);
        logic [PLRU_W-1:0] nb;
        logic [2:0]        wa;
        logic [2:0]        node;
        logic              b;
        nb   = bits;
        wa   = way << (3 - levels);
        node = 3'd0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                b        = wa[2-l];
                nb[node] = ~b;
                node     = 3'(32'd2 * node + 32'd1 + b);
            end else begin
                nb = nb;
            end
        end
        return nb;
    endfunction

    function automatic logic [2:0] plru_victim(input logic [PLRU_W-1:0] bits,
                                               input int unsigned levels);
        logic [2:0] way;
        logic [2:0] node;
        logic       b;
        way  = 3'd0;
        node = 3'd0;
        for (int l = 0; l < 3; l++) begin
            if (l < levels) begin
                b    = bits[node];
                way  = {way[1:0], b};
                node = 3'(32'd2 * node + 32'd1 + b);
            end else begin
                way = way;
            end
        end
        return way;
    endfunction

endpackage

// File: rtl/gt_plru_tree.sv
// Per-set pseudo-LRU state: reports the replacement candidate of one set and
// marks a way most-recently-used on request.
module gt_plru_tree
    import gt_cache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WAYS  = 2,
    parameter int IDX_W = 4,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_set,
    output logic [WAY_W-1:0] victim_way,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way
);

    localparam int unsigned LEVELS = $clog2(WAYS);

    logic [PLRU_W-1:0] plru_r [SETS];
    logic [2:0]        upd_way3_s;

    // Widen the way index and pick the LRU way of the looked-up set.
    always_comb begin
        upd_way3_s               = 3'd0;
        upd_way3_s[WAY_W-1:0]    = upd_way;
        victim_way               = WAY_W'(plru_victim(plru_r[rd_set], LEVELS));
    end

    // Tree state per set, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_r[s] <= 7'd0;
            end
        end else if (upd_en) begin
            plru_r[upd_set] <= plru_update(plru_r[upd_set], upd_way3_s, LEVELS);
        end
    end

endmodule

// File: rtl/gt_set_assoc_cache.sv
// N-way set-associative L1 data cache: byte reads, handshaked miss/fill,
// victim hand-off of displaced lines, pseudo-LRU replacement and counters.
module gt_set_assoc_cache
    import gt_cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int LW         = 8 * LINE_BYTES
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [7:0]        resp_data,
    output logic              resp_hit,
    output logic              miss_valid,
    output logic [ADDR_W-1:0] miss_addr,
    input  logic              fill_valid,
    input  logic              fill_src,
    input  logic [LW-1:0]     fill_data,
    output logic              evict_valid,
    output logic [ADDR_W-1:0] evict_addr,
    output logic [LW-1:0]     evict_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       victim_fills
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W = way_bits(WAYS);

    state_t state_r, state_next;

    logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
    logic [LW-1:0]     data_r  [SETS][WAYS];
    logic [WAYS-1:0]   valid_r [SETS];

    logic [ADDR_W-1:0] addr_r;
    logic [LW-1:0]     fill_line_r;
    logic              req_ready_r, resp_valid_r, resp_hit_r, miss_valid_r, evict_valid_r;
    logic [7:0]        resp_data_r;
    logic [ADDR_W-1:0] miss_addr_r, evict_addr_r;
    logic [LW-1:0]     evict_data_r;
    logic [31:0]       hit_count_r, victim_fills_r;

    logic [TAG_W-1:0]  tag_s;
    logic [IDX_W-1:0]  idx_s;
    logic [OFF_W-1:0]  off_s;
    logic              hit_s, vict_valid_s, upd_en_s;
    logic [WAY_W-1:0]  hit_way_s, vict_way_s, plru_way_s, upd_way_s;
    logic [LW-1:0]     hit_line_s;

    assign tag_s = addr_r[ADDR_W-1 -: TAG_W];
    assign idx_s = addr_r[OFF_W +: IDX_W];
    assign off_s = addr_r[OFF_W-1:0];

    gt_plru_tree #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_plru (
        .clk        (CLK),
        .rst_n      (RST_N),
        .rd_set     (idx_s),
        .victim_way (plru_way_s),
        .upd_en     (upd_en_s),
        .upd_set    (idx_s),
        .upd_way    (upd_way_s)
    );

    // Tag compare across the set; only valid ways may hit.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = {WAY_W{1'b0}};
        hit_line_s = {LW{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            if (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) begin
                hit_s      = 1'b1;
                hit_way_s  = WAY_W'(w);
                hit_line_s = data_r[idx_s][w];
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Replacement: lowest-index invalid way wins, otherwise the PLRU choice.
    always_comb begin
        vict_way_s   = plru_way_s;
        vict_valid_s = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_r[idx_s][w]) begin
                vict_way_s   = WAY_W'(w);
                vict_valid_s = 1'b0;
            end else begin
                vict_valid_s = vict_valid_s;
            end
        end
    end

    // Mark the hit way on a hit, or the refilled way on a fill, as MRU.
    always_comb begin
        upd_en_s  = ((state_r == ST_LOOKUP) && hit_s) || (state_r == ST_FILL);
        upd_way_s = (state_r == ST_FILL) ? vict_way_s : hit_way_s;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_LOOKUP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (fill_valid) begin
                    state_next = ST_FILL;
                end else begin
                    state_next = ST_MISS_WAIT;
                end
            end
            ST_FILL:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Control, response, miss/evict and counter registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            req_ready_r    <= 1'b1;
            resp_valid_r   <= 1'b0;
            resp_hit_r     <= 1'b0;
            resp_data_r    <= 8'd0;
            miss_valid_r   <= 1'b0;
            miss_addr_r    <= {ADDR_W{1'b0}};
            evict_valid_r  <= 1'b0;
            evict_addr_r   <= {ADDR_W{1'b0}};
            evict_data_r   <= {LW{1'b0}};
            hit_count_r    <= 32'd0;
            victim_fills_r <= 32'd0;
            addr_r         <= {ADDR_W{1'b0}};
            fill_line_r    <= {LW{1'b0}};
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= {WAYS{1'b0}};
            end
        end else begin
            req_ready_r   <= (state_next == ST_IDLE);
            resp_valid_r  <= 1'b0;
            evict_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r <= req_addr;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_s) begin
                        resp_valid_r <= 1'b1;
                        resp_hit_r   <= 1'b1;
                        resp_data_r  <= hit_line_s[{off_s, 3'b000} +: 8];
                        if (hit_count_r != 32'hFFFF_FFFF) begin
                            hit_count_r <= hit_count_r + 32'd1;
                        end
                    end else begin
                        miss_valid_r <= 1'b1;
                        miss_addr_r  <= {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                ST_MISS_WAIT: begin
                    if (fill_valid) begin
                        miss_valid_r <= 1'b0;
                        fill_line_r  <= fill_data;
                        if (fill_src && (victim_fills_r != 32'hFFFF_FFFF)) begin
                            victim_fills_r <= victim_fills_r + 32'd1;
                        end
                    end
                end
                ST_FILL: begin
                    evict_valid_r <= vict_valid_s;
                    if (vict_valid_s) begin
                        evict_addr_r <= {tag_r[idx_s][vict_way_s], idx_s, {OFF_W{1'b0}}};
                        evict_data_r <= data_r[idx_s][vict_way_s];
                    end
                    valid_r[idx_s][vict_way_s] <= 1'b1;
                    resp_valid_r <= 1'b1;
                    resp_hit_r   <= 1'b0;
                    resp_data_r  <= fill_line_r[{off_s, 3'b000} +: 8];
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage; contents survive reset, validity does not.
    always_ff @(posedge CLK) begin
        if (RST_N && (state_r == ST_FILL)) begin
            tag_r[idx_s][vict_way_s]  <= tag_s;
            data_r[idx_s][vict_way_s] <= fill_line_r;
        end
    end

    assign req_ready    = req_ready_r;
    assign resp_valid   = resp_valid_r;
    assign resp_data    = resp_data_r;
    assign resp_hit     = resp_hit_r;
    assign miss_valid   = miss_valid_r;
    assign miss_addr    = miss_addr_r;
    assign evict_valid  = evict_valid_r;
    assign evict_addr   = evict_addr_r;
    assign evict_data   = evict_data_r;
    assign hit_count    = hit_count_r;
    assign victim_fills = victim_fills_r;

endmodule

// File: tb/tb_gt_set_assoc_cache.sv
// Self-checking bench for gt_set_assoc_cache (SETS=16, WAYS=2, LINE_BYTES=32).
module tb_gt_set_assoc_cache;

    localparam int ADDR_W = 32;
    localparam int LW     = 256;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = 32'd0;
    logic              resp_valid;
    logic [7:0]        resp_data;
    logic              resp_hit;
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              fill_valid = 1'b0;
    logic              fill_src = 1'b0;
    logic [LW-1:0]     fill_data = {LW{1'b0}};
    logic              evict_valid;
    logic [ADDR_W-1:0] evict_addr;
    logic [LW-1:0]     evict_data;
    logic [31:0]       hit_count;
    logic [31:0]       victim_fills;

    gt_set_assoc_cache #(
        .ADDR_W(32), .LINE_BYTES(32), .SETS(16), .WAYS(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .miss_valid(miss_valid), .miss_addr(miss_addr),
        .fill_valid(fill_valid), .fill_src(fill_src), .fill_data(fill_data),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .hit_count(hit_count), .victim_fills(victim_fills)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hits_model = 0;
    int vf_model = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic hit; logic [7:0] data; int acc; } resp_t;
    typedef struct { logic [31:0] addr; logic [LW-1:0] data; } ev_t;
    typedef struct {
        logic [31:0] addr; logic hit; logic [7:0] byte_exp; logic [7:0] fill_base;
        logic src; logic ev; logic [31:0] ev_addr; logic [7:0] ev_base;
    } vec_t;

    resp_t exp_q[$];
    ev_t   ev_q[$];
    vec_t  vecs[12];

    function automatic logic [LW-1:0] mk_line(input logic [7:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < 32; i++) l[i*8 +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pops expectations whenever the DUT emits a response or eviction.
    always @(negedge CLK) begin
        resp_t r;
        ev_t   e;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", LW'(resp_valid), LW'(0));
            end else begin
                r = exp_q.pop_front();
                check("resp_hit", LW'(resp_hit), LW'(r.hit));
                check("resp_data", LW'(resp_data), LW'(r.data));
                if (r.hit) check("hit_latency", LW'(cyc - r.acc), LW'(2));
            end
        end
        if (evict_valid === 1'b1) begin
            if (ev_q.size() == 0) begin
                check("evict_unexpected", LW'(evict_valid), LW'(0));
            end else begin
                e = ev_q.pop_front();
                check("evict_addr", LW'(evict_addr), LW'(e.addr));
                check("evict_data", evict_data, e.data);
            end
        end
    end

    task automatic read_txn(input logic [31:0] addr, input logic exp_hit, input logic [7:0] exp_byte,
                            input logic [7:0] fill_base, input logic src,
                            input logic exp_ev, input logic [31:0] ev_addr, input logic [7:0] ev_base);
        resp_t r;
        ev_t   e;
        int    n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        check("req_ready", LW'(req_ready), LW'(1));
        r.hit = exp_hit; r.data = exp_byte; r.acc = cyc;
        exp_q.push_back(r);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge CLK);
        req_valid = 1'b0;
        if (!exp_hit) begin
            n = 0;
            while (miss_valid !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
            check("miss_valid", LW'(miss_valid), LW'(1));
            check("miss_addr", LW'(miss_addr), LW'(addr & ~32'h1F));
            if (exp_ev) begin
                e.addr = ev_addr; e.data = mk_line(ev_base);
                ev_q.push_back(e);
            end
            repeat (2) @(negedge CLK);
            check("miss_held", LW'(miss_valid), LW'(1));
            fill_valid = 1'b1; fill_data = mk_line(fill_base); fill_src = src;
            @(negedge CLK);
            fill_valid = 1'b0; fill_src = 1'b0;
            if (src) vf_model++;
        end else begin
            hits_model++;
        end
        n = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 20) begin @(negedge CLK); n++; end
        check("resp_pending", LW'(exp_q.size()), LW'(0));
        check("evict_pending", LW'(ev_q.size()), LW'(0));
        exp_q.delete();
        ev_q.delete();
        check("miss_clear", LW'(miss_valid), LW'(0));
        check("hit_count", LW'(hit_count), LW'(hits_model));
        check("victim_fills", LW'(victim_fills), LW'(vf_model));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{32'h0000_0040, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[1]  = '{32'h0000_0045, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[2]  = '{32'h0000_0240, 1'b0, 8'h20, 8'h20, 1'b1, 1'b0, 32'h0, 8'h00};
        vecs[3]  = '{32'h0000_0440, 1'b0, 8'h40, 8'h40, 1'b0, 1'b1, 32'h40, 8'h00};
        vecs[4]  = '{32'h0000_025F, 1'b1, 8'h3F, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[5]  = '{32'h0000_0640, 1'b0, 8'h60, 8'h60, 1'b1, 1'b1, 32'h440, 8'h40};
        vecs[6]  = '{32'h0000_0241, 1'b1, 8'h21, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[7]  = '{32'h0000_0647, 1'b1, 8'h67, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[8]  = '{32'h0000_0080, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[9]  = '{32'h0000_009F, 1'b1, 8'h9F, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};
        vecs[10] = '{32'hFFFF_FFE3, 1'b0, 8'hA3, 8'hA0, 1'b1, 1'b0, 32'h0, 8'h00};
        vecs[11] = '{32'hFFFF_FFFF, 1'b1, 8'hBF, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00};

        repeat (3) @(negedge CLK);
        check("rst_req_ready", LW'(req_ready), LW'(1));
        check("rst_resp_valid", LW'(resp_valid), LW'(0));
        check("rst_miss_valid", LW'(miss_valid), LW'(0));
        check("rst_evict_valid", LW'(evict_valid), LW'(0));
        check("rst_hit_count", LW'(hit_count), LW'(0));
        check("rst_victim_fills", LW'(victim_fills), LW'(0));
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            read_txn(vecs[i].addr, vecs[i].hit, vecs[i].byte_exp, vecs[i].fill_base,
                     vecs[i].src, vecs[i].ev, vecs[i].ev_addr, vecs[i].ev_base);
        end

        // Reset while waiting for a fill: the miss is abandoned and a late fill ignored.
        req_valid = 1'b1; req_addr = 32'h0000_0840;
        @(negedge CLK);
        req_valid = 1'b0;
        n = 0;
        while (miss_valid !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
        check("mid_miss_valid", LW'(miss_valid), LW'(1));
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        hits_model = 0;
        vf_model = 0;
        check("mid_rst_ready", LW'(req_ready), LW'(1));
        check("mid_rst_miss", LW'(miss_valid), LW'(0));
        check("mid_rst_hits", LW'(hit_count), LW'(0));
        fill_valid = 1'b1; fill_src = 1'b1; fill_data = mk_line(8'hEE);
        @(negedge CLK);
        fill_valid = 1'b0; fill_src = 1'b0;
        repeat (3) @(negedge CLK);
        check("late_fill_vf", LW'(victim_fills), LW'(0));
        check("late_fill_ready", LW'(req_ready), LW'(1));

        // Valid bits were cleared: a previously cached line misses, no eviction.
        read_txn(32'h0000_0640, 1'b0, 8'hC0, 8'hC0, 1'b0, 1'b0, 32'h0, 8'h00);
        read_txn(32'h0000_0645, 1'b1, 8'hC5, 8'h00, 1'b0, 1'b0, 32'h0, 8'h00);
        read_txn(32'h0000_0840, 1'b0, 8'hD0, 8'hD0, 1'b1, 1'b0, 32'h0, 8'h00);
        read_txn(32'h0000_0A5E, 1'b0, 8'hFE, 8'hE0, 1'b0, 1'b1, 32'h640, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
